// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the RV32/RV64 pipeline stages: opcode and load
// funct3 encodings plus the MEM/WB payload record.
// The payload struct is sized for the widest configuration (64-bit data,
// up to 8-bit register index); narrower stages zero-extend into it.
package rv_pipe_pkg;

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int PL_XLEN = 64;
    localparam int PL_RIDX = 8;

    typedef struct packed {
        logic               wer;
        logic [PL_RIDX-1:0] rd;
        logic [PL_XLEN-1:0] wbdata;
        logic               misalign;
    } memwb_t;

endpackage

// File: rtl/mem_wb_pipe_if.sv
// MEM/WB stage bus: upstream (EX/MEM side) and downstream (write-back side).
// Handshake: a beat moves on a rising edge where valid and ready are both 1.
// A producer holds valid and its payload stable until the beat moves; ready
// may change freely and a consumer never waits on valid to raise ready.
interface mem_wb_pipe_if #(
    parameter int XLEN = 32,
    parameter int RIDX = 5,
    parameter int OPW  = 7
);
    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  in_op;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_daddr;
    logic            in_wer;
    logic [RIDX-1:0] in_rd;
    logic [XLEN-1:0] in_regdata;
    logic [XLEN-1:0] in_drdata;

    logic            out_valid;
    logic            out_ready;
    logic            out_wer;
    logic [RIDX-1:0] out_rd;
    logic [XLEN-1:0] out_wbdata;
    logic            out_misalign;

    // Environment side: feeds the stage and accepts its results.
    modport master (
        output in_valid, in_op, in_funct3, in_daddr, in_wer, in_rd,
               in_regdata, in_drdata, out_ready,
        input  in_ready, out_valid, out_wer, out_rd, out_wbdata, out_misalign
    );

    // Stage side.
    modport slave (
        input  in_valid, in_op, in_funct3, in_daddr, in_wer, in_rd,
               in_regdata, in_drdata, out_ready,
        output in_ready, out_valid, out_wer, out_rd, out_wbdata, out_misalign
    );
endinterface

// File: rtl/mem_wb_pipe_load_align.sv
// Combinational load formatter: picks the addressed byte/half/word lane out
// of the raw memory word, sign- or zero-extends it, and flags misalignment.
// Non-loads pass the ALU result straight through.
module load_align
    import rv_pipe_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int OPW    = 7,
    localparam int LANE_W = (XLEN == 64) ? 3 : 2
) (
    input  logic [OPW-1:0]    i_op,
    input  logic [2:0]        i_funct3,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [XLEN-1:0]   i_regdata,
    input  logic [XLEN-1:0]   i_drdata,
    output logic [XLEN-1:0]   o_wbdata,
    output logic              o_misalign
);
    logic            w_is_load;
    logic [XLEN-1:0] w_shifted;

    assign w_is_load = (i_op == OPW'(OP_LOAD));
    // Addressed byte moved down to bit 0; wider accesses read upward from it.
    assign w_shifted = i_drdata >> {i_lane, 3'b000};

    // Decode funct3 into extract/extend and the alignment rule for its size.
    always_comb begin
        o_wbdata   = i_regdata;
        o_misalign = 1'b0;
        if (w_is_load) begin
            o_wbdata = i_drdata;
            case (i_funct3)
                F3_LB:  o_wbdata = XLEN'($signed(w_shifted[7:0]));
                F3_LBU: o_wbdata = XLEN'(w_shifted[7:0]);
                F3_LH: begin
                    o_wbdata   = XLEN'($signed(w_shifted[15:0]));
                    o_misalign = i_lane[0];
                end
                F3_LHU: begin
                    o_wbdata   = XLEN'(w_shifted[15:0]);
                    o_misalign = i_lane[0];
                end
                F3_LW: begin
                    o_wbdata   = XLEN'($signed(w_shifted[31:0]));
                    o_misalign = (i_lane[1:0] != 2'b00);
                end
                F3_LD: begin
                    // Doubleword only exists on RV64; RV32 treats it as raw.
                    if (XLEN == 64) begin
                        o_wbdata   = w_shifted;
                        o_misalign = (i_lane != '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with elastic valid/ready handshake, a two-entry
// (main + skid) store, flush, and in-stage load formatting.
// Optional retire counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_pipe
    import rv_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RIDX = 5,
    parameter int OPW  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    mem_wb_pipe_if.slave bus,
    output logic [63:0] retired
);
    localparam int LANE_W = (XLEN == 64) ? 3 : 2;

    logic            r_main_valid;
    logic            r_skid_valid;
    logic            r_in_ready;
    memwb_t          r_main;
    memwb_t          r_skid;
    memwb_t          w_new;
    logic [XLEN-1:0] w_fmt_data;
    logic            w_fmt_mis;
    logic            w_up;
    logic            w_down;
    logic [XLEN+$bits(memwb_t)-1:0] w_unused;

    load_align #(.XLEN(XLEN), .OPW(OPW)) u_align (
        .i_op       (bus.in_op),
        .i_funct3   (bus.in_funct3),
        .i_lane     (bus.in_daddr[LANE_W-1:0]),
        .i_regdata  (bus.in_regdata),
        .i_drdata   (bus.in_drdata),
        .o_wbdata   (w_fmt_data),
        .o_misalign (w_fmt_mis)
    );

    // Build the captured entry; write enable is already qualified here.
    always_comb begin
        w_new          = '0;
        w_new.misalign = w_fmt_mis;
        w_new.wbdata   = PL_XLEN'(w_fmt_data);
        w_new.rd       = PL_RIDX'(bus.in_rd);
        w_new.wer      = bus.in_wer & (bus.in_rd != '0) & ~w_fmt_mis;
    end

    assign w_up   = bus.in_valid & r_in_ready;
    assign w_down = r_main_valid & bus.out_ready;

    // Upper address bits and the padding of the wide payload carry no meaning.
    assign w_unused = {bus.in_daddr, r_main};

    // Main/skid storage: main drives the outputs, skid absorbs one entry
    // accepted while main is stalled. in_ready is a flop mirroring !skid_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (!r_main_valid) begin
            if (w_up) begin
                r_main       <= w_new;
                r_main_valid <= 1'b1;
            end
        end else if (w_down) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_up) begin
                r_main <= w_new;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_up) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_main_valid;
    assign bus.out_wer      = r_main.wer;
    assign bus.out_rd       = r_main.rd[RIDX-1:0];
    assign bus.out_wbdata   = r_main.wbdata[XLEN-1:0];
    assign bus.out_misalign = r_main.misalign;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [63:0] r_retired;

    // Count every entry handed to write-back; wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_down) begin
            r_retired <= r_retired + 64'd1;
        end
    end

    assign retired = r_retired;
`else
    assign retired = '0;
`endif
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: table of formatted-load vectors plus
// hand-written backpressure, flush and reset sequences.
module tb_mem_wb_pipe;
    import rv_pipe_pkg::*;

    localparam int XLEN = 32;
    localparam int RIDX = 5;
    localparam int OPW  = 7;
    localparam int NV   = 13;
`ifdef MEM_WB_RETIRE_CNT_EN
    localparam bit RET_EN = 1'b1;
`else
    localparam bit RET_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [63:0] retired;
    int          n_vec = 0;
    int          n_err = 0;

    mem_wb_pipe_if #(.XLEN(XLEN), .RIDX(RIDX), .OPW(OPW)) bus();

    mem_wb_pipe #(.XLEN(XLEN), .RIDX(RIDX), .OPW(OPW)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .bus     (bus),
        .retired (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] daddr;
        logic [4:0]  rd;
        logic        wer;
        logic [31:0] regdata;
        logic [31:0] drdata;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_wer;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mkv(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] daddr, input logic [4:0] rd,
                                 input logic wer, input logic [31:0] regdata,
                                 input logic [31:0] drdata, input logic chk_data,
                                 input logic [31:0] exp_data, input logic exp_wer,
                                 input logic exp_mis);
        vec_t v;
        v.op = op; v.f3 = f3; v.daddr = daddr; v.rd = rd; v.wer = wer;
        v.regdata = regdata; v.drdata = drdata; v.chk_data = chk_data;
        v.exp_data = exp_data; v.exp_wer = exp_wer; v.exp_mis = exp_mis;
        return v;
    endfunction

    function automatic logic [63:0] exp_ret(input int n);
        return RET_EN ? 64'(n) : 64'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] daddr,
                         input logic [4:0] rd, input logic wer, input logic [31:0] regdata,
                         input logic [31:0] drdata);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_funct3  = f3;
        bus.in_daddr   = daddr;
        bus.in_rd      = rd;
        bus.in_wer     = wer;
        bus.in_regdata = regdata;
        bus.in_drdata  = drdata;
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_wer"}, bus.out_wer, 0);
        check({tag, "_out_rd"}, bus.out_rd, 0);
        check({tag, "_out_wbdata"}, bus.out_wbdata, 0);
        check({tag, "_out_misalign"}, bus.out_misalign, 0);
        check({tag, "_retired"}, retired, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        //            op     f3    daddr        rd  wer regdata        drdata         chk  exp_data       wer  mis
        vecs[0]  = mkv(7'h03, 3'd0, 32'h1003, 5'd5,  1, 32'h0,        32'h80FF_1234, 1, 32'hFFFF_FF80, 1, 0);
        vecs[1]  = mkv(7'h03, 3'd5, 32'h1002, 5'd6,  1, 32'h0,        32'hBEEF_0000, 1, 32'h0000_BEEF, 1, 0);
        vecs[2]  = mkv(7'h03, 3'd1, 32'h1001, 5'd7,  1, 32'h0,        32'hBEEF_0000, 0, 32'h0,         0, 1);
        vecs[3]  = mkv(7'h03, 3'd4, 32'h2001, 5'd8,  1, 32'h0,        32'h1234_8056, 1, 32'h0000_0080, 1, 0);
        vecs[4]  = mkv(7'h03, 3'd1, 32'h2002, 5'd9,  1, 32'h0,        32'h8001_7FFF, 1, 32'hFFFF_8001, 1, 0);
        vecs[5]  = mkv(7'h03, 3'd2, 32'h2000, 5'd31, 1, 32'h0,        32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1, 0);
        vecs[6]  = mkv(7'h03, 3'd2, 32'h2002, 5'd10, 1, 32'h0,        32'hDEAD_BEEF, 0, 32'h0,         0, 1);
        vecs[7]  = mkv(7'h33, 3'd0, 32'h0,    5'd0,  1, 32'h0000_1234, 32'h5555_5555, 1, 32'h0000_1234, 0, 0);
        vecs[8]  = mkv(7'h13, 3'd0, 32'h1,    5'd9,  1, 32'hCAFE_F00D, 32'h1111_1111, 1, 32'hCAFE_F00D, 1, 0);
        vecs[9]  = mkv(7'h03, 3'd0, 32'h0,    5'd3,  0, 32'h0,        32'h0000_007F, 1, 32'h0000_007F, 0, 0);
        vecs[10] = mkv(7'h03, 3'd6, 32'h3,    5'd4,  1, 32'h0,        32'h89AB_CDEF, 1, 32'h89AB_CDEF, 1, 0);
        vecs[11] = mkv(7'h03, 3'd5, 32'h3,    5'd11, 1, 32'h0,        32'h89AB_CDEF, 0, 32'h0,         0, 1);
        vecs[12] = mkv(7'h03, 3'd0, 32'h1,    5'd12, 1, 32'h0,        32'h0000_FF00, 1, 32'hFFFF_FFFF, 1, 0);

        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(7'h0, 3'd0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
        idle_in();

        // Reset state
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_retired", retired, 0);

        // Formatting vectors, one per cycle with write-back always ready
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].daddr, vecs[i].rd, vecs[i].wer,
                  vecs[i].regdata, vecs[i].drdata);
            @(negedge clk);
            check($sformatf("v%0d_out_valid", i), bus.out_valid, 1);
            check($sformatf("v%0d_out_rd", i), bus.out_rd, vecs[i].rd);
            check($sformatf("v%0d_out_wer", i), bus.out_wer, vecs[i].exp_wer);
            check($sformatf("v%0d_out_misalign", i), bus.out_misalign, vecs[i].exp_mis);
            if (vecs[i].chk_data)
                check($sformatf("v%0d_out_wbdata", i), bus.out_wbdata, vecs[i].exp_data);
        end
        idle_in();
        @(negedge clk);
        check("drain_out_valid", bus.out_valid, 0);
        check("drain_retired", retired, exp_ret(NV));

        // Backpressure: A into main, B into skid, C stalls
        bus.out_ready = 1'b0;
        drive(7'h33, 3'd0, 32'h0, 5'd1, 1'b1, 32'hAAAA_0001, 32'h0);
        @(negedge clk);
        check("bp_a_valid", bus.out_valid, 1);
        check("bp_a_data", bus.out_wbdata, 32'hAAAA_0001);
        check("bp_a_in_ready", bus.in_ready, 1);
        drive(7'h33, 3'd0, 32'h0, 5'd2, 1'b1, 32'hBBBB_0002, 32'h0);
        @(negedge clk);
        check("bp_b_in_ready", bus.in_ready, 0);
        check("bp_b_hold_data", bus.out_wbdata, 32'hAAAA_0001);
        drive(7'h33, 3'd0, 32'h0, 5'd3, 1'b1, 32'hCCCC_0003, 32'h0);
        @(negedge clk);
        check("bp_c_in_ready", bus.in_ready, 0);
        check("bp_c_hold_data", bus.out_wbdata, 32'hAAAA_0001);
        check("bp_c_hold_rd", bus.out_rd, 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_b_data", bus.out_wbdata, 32'hBBBB_0002);
        check("bp_out_b_rd", bus.out_rd, 2);
        check("bp_out_b_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("bp_out_c_valid", bus.out_valid, 1);
        check("bp_out_c_data", bus.out_wbdata, 32'hCCCC_0003);
        check("bp_out_c_rd", bus.out_rd, 3);
        idle_in();
        @(negedge clk);
        check("bp_empty_valid", bus.out_valid, 0);
        check("bp_retired", retired, exp_ret(NV + 3));

        // Flush with both entries full and a new entry offered
        bus.out_ready = 1'b0;
        drive(7'h33, 3'd0, 32'h0, 5'd4, 1'b1, 32'hDDDD_0004, 32'h0);
        @(negedge clk);
        check("fl_d_data", bus.out_wbdata, 32'hDDDD_0004);
        drive(7'h33, 3'd0, 32'h0, 5'd5, 1'b1, 32'hEEEE_0005, 32'h0);
        @(negedge clk);
        check("fl_full_in_ready", bus.in_ready, 0);
        flush = 1'b1;
        drive(7'h33, 3'd0, 32'h0, 5'd6, 1'b1, 32'hFFFF_0006, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        idle_in();
        check("fl_out_valid", bus.out_valid, 0);
        check("fl_in_ready", bus.in_ready, 1);
        check("fl_retired", retired, exp_ret(NV + 3));
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("fl_quiet%0d_valid", k), bus.out_valid, 0);
        end
        check("fl_quiet_retired", retired, exp_ret(NV + 3));
        drive(7'h33, 3'd0, 32'h0, 5'd12, 1'b1, 32'h0000_600D, 32'h0);
        @(negedge clk);
        check("fl_g_valid", bus.out_valid, 1);
        check("fl_g_data", bus.out_wbdata, 32'h0000_600D);
        check("fl_g_rd", bus.out_rd, 12);
        idle_in();
        @(negedge clk);
        check("fl_g_retired", retired, exp_ret(NV + 4));

        // Reset beats a simultaneous flush and accept, and clears payload
        bus.out_ready = 1'b0;
        drive(7'h33, 3'd0, 32'h0, 5'd7, 1'b1, 32'h0000_0077, 32'h0);
        @(negedge clk);
        check("rr_h_wer", bus.out_wer, 1);
        rst = 1'b1;
        flush = 1'b1;
        drive(7'h33, 3'd0, 32'h0, 5'd8, 1'b1, 32'h0000_0088, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        idle_in();
        check_cleared("rr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised successor to the MEM/WB stage register of the pipelined RV32 core.
- Sits between the data-memory stage and register-file write-back.
- Adds synchronous reset, a valid/ready elastic handshake with a 2-entry skid buffer, and flush.
- Does in-stage load formatting (byte/half extract plus sign/zero extend), so write-back receives final data.

Parameters:
- XLEN, 32, datapath and address width (32 or 64).
- RIDX, 5, register index width.
- OPW, 7, opcode field width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all held entries this cycle.
- in_valid  in  1  upstream (EX/MEM) entry valid.
- in_ready  out  1  stage can accept. Registered output, equal to !skid_valid.
- in_op  in  OPW  opcode.
- in_funct3  in  3  load size/sign.
- in_daddr  in  XLEN  data address.
- in_wer  in  1  register write enable.
- in_rd  in  RIDX  destination register.
- in_regdata  in  XLEN  ALU/result data.
- in_drdata  in  XLEN  raw data-memory read word.
- out_valid  out  1  entry available to write-back.
- out_ready  in  1  write-back accepts.
- out_wer  out  1  qualified write enable.
- out_rd  out  RIDX  destination.
- out_wbdata  out  XLEN  final write-back value.
- out_misalign  out  1  load address misaligned for its size.
- retired  out  64  retire count (see Optional Feature).

Behaviour:
- Reset (rst=1 at posedge): main_valid=0, skid_valid=0, all payload registers 0.
  - out_valid=0, out_wer=0, out_rd=0, out_wbdata=0, out_misalign=0, in_ready=1.
  - Reset dominates flush and all handshakes.
- Transfers:
  - Upstream transfer when in_valid & in_ready.
  - Downstream transfer when out_valid & out_ready.
- Latency: 1 cycle from upstream transfer to out_valid, with payload formatted before capture.
- Storage is a main register (drives outputs) plus a skid register.
  - Empty -> accept: load main.
  - Main full, out_ready=1, accept: main <= new entry.
  - Main full, out_ready=0, accept: skid <= new entry, so in_ready falls next cycle.
  - Downstream transfer with skid full: main <= skid, skid cleared.
  - Both full: in_ready=0, nothing accepted.
- Order is strictly FIFO; no entry is dropped or duplicated except by flush.
- Flush: main_valid=0 and skid_valid=0 next cycle. Flush beats a simultaneous accept (incoming entry discarded). Payload need not clear.
- Load detect: in_op == 7'b0000011.
- Lane select by in_daddr[1:0] (and [2] when XLEN=64).
- funct3 decode:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: word, sign-extended when XLEN=64.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 011 LD: valid only when XLEN=64.
  - Other values: data = raw word, misalign=0.
- Non-load: out_wbdata = in_regdata.
- Misalign:
  - Half with addr[0]=1 -> out_misalign=1.
  - Word with addr[1:0]!=0 -> out_misalign=1.
  - When misaligned, out_wer is forced to 0.
- x0: out_wer forced to 0 when rd==0.
- out_* hold stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro MEM_WB_RETIRE_CNT_EN.
- Defined: 64-bit counter, cleared by reset, increments by 1 on each downstream transfer and wraps at 2^64-1 -> 0. Flushed entries are not counted. Value appears on retired.
- Undefined: retired is tied to 0 and no counter logic is present.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - opcode constants (OP_LOAD=7'b0000011),
  - funct3 load encodings (F3_LB..F3_LD),
  - a typedef for the mem/wb payload struct (wer, rd, wbdata, misalign).
- One sub-module, load_align: combinational lane extract, extend and misalign detect, parametrised by XLEN.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, retired=0.
- LB, daddr=0x1003, drdata=0x80FF_1234, rd=5, wer=1 -> next cycle out_wbdata=0xFFFF_FF80, out_wer=1, out_rd=5.
- LHU, daddr=0x1002, drdata=0xBEEF_0000 -> 0x0000_BEEF. LH, daddr=0x1001 -> out_misalign=1, out_wer=0.
- Backpressure: out_ready=0, push A, B, C.
  - A and B held; in_ready=0 after B; C stalls.
  - out_ready=1 -> A, B, C emerge in order, one per cycle.
- flush with in_valid=1 and both entries full -> next cycle out_valid=0. The flushed entries never appear, and retired is unchanged (feature on).
- Non-load op 0110011, rd=0, wer=1, regdata=0x1234 -> out_wer=0, out_wbdata=0x0000_1234.
